// File: rtl/rr_arbiter4_if.sv
// Requester-side bundle for rr_arbiter4: request lines in, registered grant/priority status out.
interface rr_arbiter4_if;
   logic [3:0] req;
   logic [3:0] grant;
   logic       grant_valid;
   logic [1:0] grant_id;
   logic [3:0] ptr;
   logic       expired;

   modport master (output req, input grant, grant_valid, grant_id, ptr, expired);
   modport slave  (input req, output grant, grant_valid, grant_id, ptr, expired);
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a one-hot rotating priority ring and a bounded grant tenure.
module rr_arbiter4 #(
   parameter int MAX_HOLD = 8
) (
   input  logic          clk,
   input  logic          reset,
   rr_arbiter4_if.slave  bus
);
   localparam logic [7:0] HMAX = 8'(MAX_HOLD);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t     r_state, w_state_nxt;
   logic [3:0] r_grant, w_grant_nxt;
   logic [3:0] r_ptr,   w_ptr_nxt;
   logic [7:0] r_hold,  w_hold_nxt;
   logic       r_exp,   w_exp_nxt;
   logic [3:0] w_others, w_ptr_rot;

   // First asserted request scanning upward from the ptr position, wrapping 3->0.
   function automatic logic [3:0] f_pick(input logic [3:0] rq, input logic [3:0] pt);
      logic [3:0] g;
      logic [1:0] idx;
      g   = '0;
      idx = '0;
      for (int s = 0; s < 4; s++)
         if (pt[s])
            for (int k = 3; k >= 0; k--) begin
               idx = 2'(s + k);
               if (rq[idx]) g = 4'b0001 << idx;
            end
      return g;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_grant <= 4'b0000;
         r_ptr   <= 4'b0001;
         r_hold  <= 8'd0;
         r_exp   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_ptr   <= w_ptr_nxt;
         r_hold  <= w_hold_nxt;
         r_exp   <= w_exp_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_ptr_nxt   = r_ptr;
      w_hold_nxt  = r_hold;
      w_exp_nxt   = 1'b0;
      w_others    = bus.req & ~r_grant;
      w_ptr_rot   = {r_grant[2:0], r_grant[3]};
      case (r_state)
         S_IDLE: begin
            if (|bus.req) begin
               w_grant_nxt = f_pick(bus.req, r_ptr);
               w_hold_nxt  = 8'd1;
               w_state_nxt = S_GRANT;
            end
         end
         S_GRANT: begin
            if (~|(bus.req & r_grant)) begin
               w_ptr_nxt = w_ptr_rot;
               if (|w_others) begin
                  // Handover on the releasing edge, scanned from the freshly rotated ptr.
                  w_grant_nxt = f_pick(w_others, w_ptr_rot);
                  w_hold_nxt  = 8'd1;
               end else begin
                  w_grant_nxt = 4'b0000;
                  w_hold_nxt  = 8'd0;
                  w_state_nxt = S_IDLE;
               end
            end else if (|w_others) begin
               if (r_hold == HMAX) begin
                  w_ptr_nxt   = w_ptr_rot;
                  w_grant_nxt = f_pick(w_others, w_ptr_rot);
                  w_hold_nxt  = 8'd1;
                  w_exp_nxt   = 1'b1;
               end else begin
                  w_hold_nxt  = r_hold + 8'd1;
               end
            end else begin
               w_hold_nxt = (r_hold == HMAX) ? HMAX : r_hold + 8'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.grant       = r_grant;
      bus.grant_valid = |r_grant;
      bus.ptr         = r_ptr;
      bus.expired     = r_exp;
      bus.grant_id    = 2'd0;
      case (r_grant)
         4'b0010: bus.grant_id = 2'd1;
         4'b0100: bus.grant_id = 2'd2;
         4'b1000: bus.grant_id = 2'd3;
         default: bus.grant_id = 2'd0;
      endcase
   end
endmodule
